// File: rtl/mod_counter_bank_if.sv
// Control/status bundle for the modulo counter bank.
// There is no handshake: every control bit is sampled on each rising clock,
// and cnt/tc/ovf are registered outputs valid one cycle after the inputs.
interface mod_counter_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 2
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       up;
  logic [NUM_CH-1:0]       sat_mode;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*WIDTH-1:0] load_val;
  logic [NUM_CH*WIDTH-1:0] max_val;
  logic [NUM_CH*WIDTH-1:0] cnt;
  logic [NUM_CH-1:0]       tc;
  logic [NUM_CH-1:0]       ovf;

  modport master (
    output en, up, sat_mode, clr, load, load_val, max_val,
    input  cnt, tc, ovf
  );

  modport slave (
    input  en, up, sat_mode, clr, load, load_val, max_val,
    output cnt, tc, ovf
  );
endinterface

// File: rtl/mod_counter_bank.sv
// Bank of independent modulo counters with programmable terminal value,
// up/down direction, wrap/saturate mode, clear, load, terminal-count pulse
// and sticky overflow flag.
module mod_counter_bank #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned RST_VAL = 0
) (
  input logic               clk,
  input logic               rstn,
  mod_counter_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0]  cnt_q  [NUM_CH];
  logic [WIDTH-1:0]  cnt_d  [NUM_CH];
  logic [WIDTH-1:0]  max_a  [NUM_CH];
  logic [WIDTH-1:0]  load_a [NUM_CH];
  logic [NUM_CH-1:0] tc_q, tc_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] ev;

  // Unpack the per-channel terminal and load values.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      max_a[i]  = bus.max_val[i*WIDTH +: WIDTH];
      load_a[i] = bus.load_val[i*WIDTH +: WIDTH];
    end
  end

  // Next-state per channel: clr beats load beats en; ev marks a boundary event.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      tc_d[i]  = 1'b0;
      ovf_d[i] = ovf_q[i];
      ev[i]    = 1'b0;
      if (bus.clr[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (bus.load[i]) begin
        cnt_d[i] = (load_a[i] > max_a[i]) ? max_a[i] : load_a[i];
      end else if (bus.en[i]) begin
        if (bus.up[i]) begin
          // cnt above max_val (max lowered at runtime) is treated as at the bound.
          if (cnt_q[i] < max_a[i]) begin
            cnt_d[i] = cnt_q[i] + ONE;
          end else begin
            ev[i]    = 1'b1;
            cnt_d[i] = bus.sat_mode[i] ? max_a[i] : '0;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            ev[i]    = 1'b1;
            cnt_d[i] = bus.sat_mode[i] ? '0 : max_a[i];
          end else if (cnt_q[i] > max_a[i]) begin
            ev[i]    = 1'b1;
            cnt_d[i] = max_a[i];
          end else begin
            cnt_d[i] = cnt_q[i] - ONE;
          end
        end
        tc_d[i] = ev[i];
        if (ev[i]) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers; reset forces every channel back immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= RST_W;
      end
      tc_q  <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign bus.cnt[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule
